// File: rtl/arb_pkg.sv
// Shared types and constants for the eight-way round-robin arbiter.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE,
        BUSY
    } arb_state_t;

    // One-hot decode of a requester index.
    function automatic logic [N_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] one;
        one      = '0;
        one[idx] = 1'b1;
        return one;
    endfunction

endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesters and the arbiter.
interface rr_arbiter8_if;
    import arb_pkg::*;

    logic             en;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic             gnt_valid;

    modport master (output en, output req, input gnt, input gnt_valid);
    modport slave  (input en, input req, output gnt, output gnt_valid);

endinterface

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: first set request at or after ptr, with wrap,
// optionally ignoring one index.
module rr_pick8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             excl_en,
    input  logic [IDX_W-1:0] excl_idx,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [N_REQ-1:0] masked;
    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] off;

    // Drop the excluded requester from consideration.
    always_comb begin
        masked = req;
        if (excl_en) masked[excl_idx] = 1'b0;
    end

    // Rotate so that bit 0 corresponds to the current priority pointer.
    always_comb begin
        rot = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            rot[i] = masked[IDX_W'(ptr + IDX_W'(i))];
        end
    end

    // Lowest set bit of the rotated vector wins.
    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (rot[i] && !found) begin
                found = 1'b1;
                off   = IDX_W'(i);
            end
        end
    end

    // Un-rotate back to an absolute index; 3-bit addition wraps naturally.
    assign idx = ptr + off;

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-input round-robin arbiter with grant hold and contention timeout.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    rr_arbiter8_if.slave   bus
);

    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] cur, cur_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_nxt;
    logic [N_REQ-1:0] gnt_q;
    logic             gnt_valid_q;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             released;
    logic             contend;

    // While busy the current owner is excluded, so one pick serves both
    // the idle grant and the release/timeout handover.
    rr_pick8 u_pick (
        .req      (bus.req),
        .ptr      (ptr),
        .excl_en  (state == BUSY),
        .excl_idx (cur),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    // Next-state, owner, pointer and hold-counter decisions.
    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        ptr_nxt   = ptr;
        hold_nxt  = hold_cnt;
        released  = ~bus.req[cur];
        contend   = |(bus.req & ~idx_onehot(cur));

        if (!bus.en) begin
            state_nxt = IDLE;
            hold_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state_nxt = BUSY;
                        cur_nxt   = pick_idx;
                        ptr_nxt   = pick_idx + IDX_W'(1);
                        hold_nxt  = '0;
                    end
                end
                BUSY: begin
                    if (released || (hold_cnt == HOLD_LAST && contend)) begin
                        if (pick_found) begin
                            cur_nxt  = pick_idx;
                            ptr_nxt  = pick_idx + IDX_W'(1);
                            hold_nxt = '0;
                        end else begin
                            state_nxt = IDLE;
                            hold_nxt  = '0;
                        end
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_nxt = hold_cnt + CNT_W'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State and output registers; grant is decoded from the next owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cur         <= '0;
            ptr         <= '0;
            hold_cnt    <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            cur         <= cur_nxt;
            ptr         <= ptr_nxt;
            hold_cnt    <= hold_nxt;
            gnt_q       <= (state_nxt == BUSY) ? idx_onehot(cur_nxt) : '0;
            gnt_valid_q <= (state_nxt == BUSY);
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8 (MAX_HOLD=4): directed scenarios plus
// randomized traffic compared against a behavioural owner/pointer model.
module tb_rr_arbiter8;

    localparam int MAX_HOLD = 4;

    logic clk;
    logic rst_n;

    rr_arbiter8_if bus ();

    rr_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int enc(input logic [7:0] g);
        for (int i = 0; i < 8; i++) if (g[i]) return i;
        return 0;
    endfunction

    // Behavioural model: owner (-1 = none), next-priority pointer, and the
    // number of cycles the current owner has already held the grant.
    typedef struct {
        int owner;
        int ptr;
        int held;
    } mstate_t;

    mstate_t m = '{owner: -1, ptr: 0, held: 0};

    function automatic int pick(input logic [7:0] r, input int p, input int skip);
        for (int k = 0; k < 8; k++) begin
            int j;
            j = (p + k) % 8;
            if (r[j] && j != skip) return j;
        end
        return -1;
    endfunction

    function automatic mstate_t step(input mstate_t s, input logic e, input logic [7:0] r);
        mstate_t n;
        int w;
        n = s;
        if (!e) begin
            n.owner = -1;
            n.held  = 0;
            return n;
        end
        if (s.owner < 0) begin
            w = pick(r, s.ptr, -1);
        end else if (!r[s.owner] ||
                     (s.held >= MAX_HOLD && (r & ~(8'(1) << s.owner)) != 8'h00)) begin
            w = pick(r, s.ptr, s.owner);
        end else begin
            n.held = (s.held < MAX_HOLD) ? s.held + 1 : MAX_HOLD;
            return n;
        end
        if (w < 0) begin
            n.owner = -1;
            n.held  = 0;
        end else begin
            n.owner = w;
            n.ptr   = (w + 1) % 8;
            n.held  = 1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{owner: -1, ptr: 0, held: 0};
        else        m <= step(m, bus.en, bus.req);
    end

    // Every-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        logic [7:0] exp_gnt;
        exp_gnt = (m.owner >= 0) ? 8'(8'(1) << m.owner) : 8'h00;
        check("model_gnt", 32'(bus.gnt), 32'(exp_gnt));
        check("model_valid", 32'(bus.gnt_valid), 32'(m.owner >= 0));
        check("valid_matches_gnt", 32'(bus.gnt_valid), 32'(bus.gnt != 8'h00));
        check("onehot", 32'($countones(bus.gnt) <= 1), 32'd1);
    end

    task automatic step_cycle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        bus.en  = 1'b0;
        bus.req = 8'h00;
        repeat (3) step_cycle();
        check("reset_gnt", 32'(bus.gnt), 32'h0);
        check("reset_valid", 32'(bus.gnt_valid), 32'h0);

        // First grant after reset.
        rst_n   = 1'b1;
        bus.en  = 1'b1;
        bus.req = 8'b0010_0100;
        step_cycle();
        check("first_gnt", 32'(bus.gnt), 32'h04);
        check("first_enc", 32'(enc(bus.gnt)), 32'd2);

        // Handover on release with no gap.
        bus.req = 8'b0010_0000;
        step_cycle();
        check("handover_gnt", 32'(bus.gnt), 32'h20);

        // Wrap-around: owner 7, then 0.
        bus.req = 8'b1000_0000;
        step_cycle();
        check("owner7_gnt", 32'(bus.gnt), 32'h80);
        bus.req = 8'b1000_0001;
        step_cycle();
        check("owner7_hold", 32'(bus.gnt), 32'h80);
        bus.req = 8'b0000_0001;
        step_cycle();
        check("wrap_gnt", 32'(bus.gnt), 32'h01);

        // Idle, then timeout rotation between 1 and 0 (ptr is 1 here).
        bus.req = 8'h00;
        step_cycle();
        check("idle_gnt", 32'(bus.gnt), 32'h00);
        bus.req = 8'b0000_0011;
        for (int i = 0; i < 12; i++) begin
            step_cycle();
            check("timeout_seq", 32'(bus.gnt), (i < 4 || i >= 8) ? 32'h02 : 32'h01);
        end
        bus.req = 8'b0000_0001;
        for (int i = 0; i < 22; i++) begin
            step_cycle();
            check("solo_persist", 32'(bus.gnt), 32'h01);
        end

        // Enable drop preserves ptr.
        bus.req = 8'b0010_0000;
        step_cycle();
        check("owner5_gnt", 32'(bus.gnt), 32'h20);
        bus.en = 1'b0;
        step_cycle();
        check("en_drop_gnt", 32'(bus.gnt), 32'h00);
        check("en_drop_valid", 32'(bus.gnt_valid), 32'h0);
        bus.en  = 1'b1;
        bus.req = 8'b0010_0001;
        step_cycle();
        check("en_resume_gnt", 32'(bus.gnt), 32'h01);

        // Asynchronous reset mid-grant, between clock edges.
        rst_n = 1'b0;
        #1;
        check("async_rst_gnt", 32'(bus.gnt), 32'h00);
        check("async_rst_valid", 32'(bus.gnt_valid), 32'h0);
        #1;
        rst_n   = 1'b1;
        bus.req = 8'b1000_0001;
        step_cycle();
        check("post_rst_gnt", 32'(bus.gnt), 32'h01);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            step_cycle();
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                    0:       bus.req = 8'($urandom);
                    1:       bus.req = 8'(8'(1) << $urandom_range(0, 7));
                    default: bus.req = 8'($urandom) & 8'($urandom);
                endcase
            end
            bus.en = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                #1;
                check("rand_async_rst", 32'(bus.gnt), 32'h00);
                rst_n = 1'b1;
            end
        end

        step_cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
